motoro3_step_sequencer: RTL and testbench

Upstream timing source for the three `motoro3_sine_generator` phase instances. It owns the 25-bit period counter and produces `m3cnt`/`m3cntLast1` for the PWM generators. It advances the 12-position electrical step index and emits one `sgStep` code per phase, with phases 120° apart. Speed comes from `m3reg_step_cnt_reload1`; start and stop are controlled by a level `run` request.

---
 rtl/motoro3_pkg.sv | 23 ++
 rtl/motoro3_period_counter.sv | 41 ++++
 rtl/motoro3_step_sequencer.sv | 120 ++++++++++++
 tb/tb_motoro3_step_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motoro3_pkg.sv
// Shared constants, FSM encoding and modular-add helper for the motoro3 step sequencer.
package motoro3_pkg;

  localparam logic [3:0] STEP_OFF = 4'hF;
  localparam int unsigned STEP_N_DEF = 12;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStopping = 2'd2
  } seqState_e;

  // (a + b) mod n for a, b < n <= 15
  function automatic logic [3:0] stepAddMod(logic [3:0] a, logic [3:0] b, logic [3:0] n);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, n}) begin
      s = s - {1'b0, n};
    end
    return s[3:0];
  endfunction

endpackage

// File: rtl/motoro3_period_counter.sv
// Period counter with shadowed reload: m3cnt runs 0..reloadSh, cntLast1 flags the final cycle.
module motoro3_period_counter #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             loadStart,
  input  logic [CNT_W-1:0] reloadIn,
  output logic [CNT_W-1:0] cnt,
  output logic             cntLast1
);

  logic [CNT_W-1:0] reloadSh;
  logic [CNT_W-1:0] reloadClamped;
  logic [CNT_W-1:0] cntInc;

  // A zero reload would make every cycle a boundary; the shortest period is 2 cycles.
  assign reloadClamped = (reloadIn == '0) ? CNT_W'(1) : reloadIn;
  assign cntInc        = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      cntLast1 <= 1'b0;
      reloadSh <= CNT_W'(1);
    end else if (!en) begin
      cnt      <= '0;
      cntLast1 <= 1'b0;
    end else if (loadStart || cntLast1) begin
      // New period: pick up the reload register; clamped value is never 0, so last1 stays low.
      reloadSh <= reloadClamped;
      cnt      <= '0;
      cntLast1 <= 1'b0;
    end else begin
      cnt      <= cntInc;
      cntLast1 <= (cntInc == reloadSh);
    end
  end

endmodule

// File: rtl/motoro3_step_sequencer.sv
// Step sequencer: run/stop FSM, electrical step index and three 120-degree phase codes.
// Optional reverse rotation via `MOTORO3_SEQ_DIR_EN.
module motoro3_step_sequencer
  import motoro3_pkg::*;
#(
  parameter int unsigned CNT_W  = 25,
  parameter int unsigned STEP_N = STEP_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             dir,
  input  logic [CNT_W-1:0] m3reg_step_cnt_reload1,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntLast1,
  output logic [3:0]       sgStepA,
  output logic [3:0]       sgStepB,
  output logic [3:0]       sgStepC,
  output logic             stepTick,
  output logic             seqBusy
);

  localparam logic [3:0] StepN4   = 4'(STEP_N);
  localparam logic [3:0] StepLast = 4'(STEP_N - 1);
  localparam logic [3:0] OffsB    = 4'(STEP_N / 3);
  localparam logic [3:0] OffsC    = 4'((2 * STEP_N) / 3);

  seqState_e  stateQ, stateD;
  logic [3:0] stepIdxQ, stepIdxD;
  logic [3:0] stepInc;
  logic       loadStart;
  logic       advance;
  logic       busyD;

  assign stepInc = (stepIdxQ == StepLast) ? 4'd0 : stepIdxQ + 4'd1;

`ifdef MOTORO3_SEQ_DIR_EN
  logic [3:0] stepDec;
  assign stepDec = (stepIdxQ == 4'd0) ? StepLast : stepIdxQ - 4'd1;
`else
  logic unusedDir;
  assign unusedDir = dir;
`endif

  always_comb begin
    stateD    = stateQ;
    loadStart = 1'b0;
    advance   = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (run) begin
          stateD    = StRun;
          loadStart = 1'b1;
        end
      end
      StRun: begin
        if (!run) begin
          stateD = StStopping;
        end
        advance = m3cntLast1;
      end
      StStopping: begin
        // A returning request keeps the rotation seamless, including at the boundary itself.
        if (run) begin
          stateD  = StRun;
          advance = m3cntLast1;
        end else if (m3cntLast1) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  assign busyD = (stateD != StIdle);

  always_comb begin
    stepIdxD = stepIdxQ;
    if (advance) begin
`ifdef MOTORO3_SEQ_DIR_EN
      stepIdxD = dir ? stepDec : stepInc;
`else
      stepIdxD = stepInc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= StIdle;
      stepIdxQ <= 4'd0;
      seqBusy  <= 1'b0;
      stepTick <= 1'b0;
      sgStepA  <= STEP_OFF;
      sgStepB  <= STEP_OFF;
      sgStepC  <= STEP_OFF;
    end else begin
      stateQ   <= stateD;
      stepIdxQ <= stepIdxD;
      seqBusy  <= busyD;
      stepTick <= loadStart | advance;
      sgStepA  <= busyD ? stepIdxD : STEP_OFF;
      sgStepB  <= busyD ? stepAddMod(stepIdxD, OffsB, StepN4) : STEP_OFF;
      sgStepC  <= busyD ? stepAddMod(stepIdxD, OffsC, StepN4) : STEP_OFF;
    end
  end

  motoro3_period_counter #(
    .CNT_W(CNT_W)
  ) u_period_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (busyD),
    .loadStart(loadStart),
    .reloadIn (m3reg_step_cnt_reload1),
    .cnt      (m3cnt),
    .cntLast1 (m3cntLast1)
  );

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Scoreboard bench for motoro3_step_sequencer: expected step codes are queued when a step is due
// and popped on every stepTick; per-cycle counter, last1, tick and busy checks run alongside.
module tb_motoro3_step_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic        dir;
  logic [24:0] reload;
  logic [24:0] m3cnt;
  logic        m3cntLast1;
  logic [3:0]  sgStepA;
  logic [3:0]  sgStepB;
  logic [3:0]  sgStepC;
  logic        stepTick;
  logic        seqBusy;

  int          nTests;
  int          nFail;
  int          expIdx;
  logic [11:0] stepQ[$];

  motoro3_step_sequencer dut (
    .clk                   (clk),
    .rst                   (rst),
    .run                   (run),
    .dir                   (dir),
    .m3reg_step_cnt_reload1(reload),
    .m3cnt                 (m3cnt),
    .m3cntLast1            (m3cntLast1),
    .sgStepA               (sgStepA),
    .sgStepB               (sgStepB),
    .sgStepC               (sgStepC),
    .stepTick              (stepTick),
    .seqBusy               (seqBusy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] codes(input int i);
    return {4'(i), 4'((i + 4) % 12), 4'((i + 8) % 12)};
  endfunction

  function automatic int nextIdx(input int i);
`ifdef MOTORO3_SEQ_DIR_EN
    if (dir) return (i + 11) % 12;
`endif
    return (i + 1) % 12;
  endfunction

  // One clock; sample 1 time unit after the edge and pop the scoreboard on each stepTick.
  task automatic step_cycle();
    logic [11:0] exp;
    @(posedge clk);
    #1;
    if (stepTick === 1'b1) begin
      nTests++;
      if (stepQ.size() == 0) begin
        nFail++;
        $display("FAIL step_unexpected: got A=%0d B=%0d C=%0d, required no stepTick",
                 sgStepA, sgStepB, sgStepC);
      end else begin
        exp = stepQ.pop_front();
        if ({sgStepA, sgStepB, sgStepC} !== exp) begin
          nFail++;
          $display("FAIL step_codes: got A=%0d B=%0d C=%0d, required A=%0d B=%0d C=%0d",
                   sgStepA, sgStepB, sgStepC, exp[11:8], exp[7:4], exp[3:0]);
        end
      end
    end
  endtask

  task automatic expect_advance();
    expIdx = nextIdx(expIdx);
    stepQ.push_back(codes(expIdx));
  endtask

  // Observe cycles jFrom..jTo of a period with shadowed reload r (cycle r+1 is the next cnt=0).
  task automatic run_span(input int r, input int jFrom, input int jTo, input bit adv,
                          input bit busyEnd, input string name);
    int  expCnt;
    bit  expLast;
    bit  expTick;
    bit  expBusy;
    for (int j = jFrom; j <= jTo; j++) begin
      step_cycle();
      expCnt  = (j == r + 1) ? 0 : j;
      expLast = (j == r);
      expTick = adv && (j == r + 1);
      expBusy = (j == r + 1) ? busyEnd : 1'b1;
      nTests++;
      if (m3cnt !== 25'(expCnt) || m3cntLast1 !== expLast || stepTick !== expTick ||
          seqBusy !== expBusy) begin
        nFail++;
        $display("FAIL %s j=%0d: cnt=%0d last1=%b tick=%b busy=%b, required cnt=%0d last1=%b tick=%b busy=%b",
                 name, j, m3cnt, m3cntLast1, stepTick, seqBusy, expCnt, expLast, expTick, expBusy);
      end
    end
  endtask

  task automatic check_idle(input string name);
    nTests++;
    if (m3cnt !== 25'd0 || m3cntLast1 !== 1'b0 || seqBusy !== 1'b0 || stepTick !== 1'b0 ||
        {sgStepA, sgStepB, sgStepC} !== 12'hFFF) begin
      nFail++;
      $display("FAIL %s: cnt=%0d last1=%b busy=%b tick=%b steps=%h, required 0 0 0 0 fff",
               name, m3cnt, m3cntLast1, seqBusy, stepTick, {sgStepA, sgStepB, sgStepC});
    end
  endtask

  task automatic start_check(input string name);
    stepQ.push_back(codes(expIdx));
    step_cycle();
    nTests++;
    if (seqBusy !== 1'b1 || m3cnt !== 25'd0 || stepTick !== 1'b1 || stepQ.size() != 0) begin
      nFail++;
      $display("FAIL %s: busy=%b cnt=%0d tick=%b pending=%0d, required busy=1 cnt=0 tick=1 pending=0",
               name, seqBusy, m3cnt, stepTick, stepQ.size());
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    run    = 1'b0;
    dir    = 1'b0;
    reload = 25'd3;
    for (int i = 0; i < 3; i++) step_cycle();
    check_idle("reset");
    rst    = 1'b0;
    expIdx = 0;
    step_cycle();
    check_idle("reset_released_idle");
  endtask

  task automatic test_forward();
    reload = 25'd3;
    run    = 1'b1;
    start_check("forward_start");
    for (int k = 0; k < 12; k++) begin
      expect_advance();
      run_span(3, 1, 4, 1'b1, 1'b1, "forward_period");
    end
    nTests++;
    if (sgStepA !== 4'd0 || sgStepB !== 4'd4 || sgStepC !== 4'd8) begin
      nFail++;
      $display("FAIL forward_wrap: got A=%0d B=%0d C=%0d, required 0 4 8", sgStepA, sgStepB, sgStepC);
    end
  endtask

  task automatic test_reload_change();
    expect_advance();
    run_span(3, 1, 1, 1'b1, 1'b1, "reload_change_old");
    reload = 25'd9;
    run_span(3, 2, 4, 1'b1, 1'b1, "reload_change_old");
    for (int k = 0; k < 2; k++) begin
      expect_advance();
      run_span(9, 1, 10, 1'b1, 1'b1, "reload_change_new");
    end
  endtask

  task automatic test_reload_zero();
    reload = 25'd0;
    expect_advance();
    run_span(9, 1, 10, 1'b1, 1'b1, "reload_zero_prev");
    for (int k = 0; k < 3; k++) begin
      expect_advance();
      run_span(1, 1, 2, 1'b1, 1'b1, "reload_zero_clamped");
    end
  endtask

  task automatic test_stop_restart();
    int heldIdx;
    reload = 25'd5;
    expect_advance();
    run_span(1, 1, 2, 1'b1, 1'b1, "stop_prep");
    heldIdx = expIdx;
    run_span(5, 1, 1, 1'b0, 1'b1, "stop_period");
    run = 1'b0;
    run_span(5, 2, 6, 1'b0, 1'b0, "stop_period");
    check_idle("stop_idle");
    for (int i = 0; i < 3; i++) step_cycle();
    check_idle("stop_idle_hold");
    run = 1'b1;
    expIdx = heldIdx;
    start_check("stop_restart_same_idx");
    expect_advance();
    run_span(5, 1, 6, 1'b1, 1'b1, "stop_restart_period");
  endtask

  task automatic test_back_to_back();
    expect_advance();
    run_span(5, 1, 1, 1'b1, 1'b1, "b2b_period");
    run = 1'b0;
    run_span(5, 2, 2, 1'b1, 1'b1, "b2b_stopping");
    run = 1'b1;
    run_span(5, 3, 6, 1'b1, 1'b1, "b2b_resumed");
    expect_advance();
    run_span(5, 1, 6, 1'b1, 1'b1, "b2b_next");
  endtask

  task automatic test_dir();
    reload = 25'd1;
    expect_advance();
    run_span(5, 1, 6, 1'b1, 1'b1, "dir_prep");
    dir = 1'b1;
    for (int k = 0; k < 13; k++) begin
      expect_advance();
      run_span(1, 1, 2, 1'b1, 1'b1, "dir_period");
    end
    dir = 1'b0;
  endtask

  task automatic test_reset_mid();
    step_cycle();
    rst = 1'b1;
    run = 1'b0;
    step_cycle();
    check_idle("reset_mid");
    rst = 1'b0;
    step_cycle();
    check_idle("reset_mid_released");
    expIdx = 0;
    run = 1'b1;
    start_check("reset_mid_restart_idx0");
    expect_advance();
    run_span(1, 1, 2, 1'b1, 1'b1, "reset_mid_period");
    run = 1'b0;
  endtask

  initial begin
    nTests = 0;
    nFail  = 0;
    rst    = 1'b1;
    run    = 1'b0;
    dir    = 1'b0;
    reload = 25'd3;
    test_reset();
    test_forward();
    test_reload_change();
    test_reload_zero();
    test_stop_restart();
    test_back_to_back();
    test_dir();
    test_reset_mid();
    nTests++;
    if (stepQ.size() != 0) begin
      nFail++;
      $display("FAIL queue_drain: %0d step codes pending, required 0", stepQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
